// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: owns the register-file write port, merging ALU results with FIFO-buffered load results
// Ports: clk_i/rst_i (async active-low reset); alu_* unstallable ALU result; mem_* load handshake;
//        RDaddr_o/RDdata_o/RegWrite_o registered write port; pending_o live queued-rd mask; count_o FIFO occupancy
module wb_write_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alu_valid_i,
    input  logic [4:0]                 alu_rd_i,
    input  logic [31:0]                alu_data_i,
    input  logic                       mem_valid_i,
    input  logic [4:0]                 mem_rd_i,
    input  logic [31:0]                mem_data_i,
    output logic                       mem_ready_o,
    output logic [4:0]                 RDaddr_o,
    output logic [31:0]                RDdata_o,
    output logic                       RegWrite_o,
    output logic [31:0]                pending_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [4:0]       q_rd [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_vld, q_kill;
    logic [AW-1:0]    wp, rp;
    logic             alu_live, acc, pop, bypass, push;
    assign mem_ready_o = count_o < CW'(DEPTH);
    always_comb begin
        alu_live = alu_valid_i && alu_rd_i != 5'd0;
        acc      = mem_valid_i && mem_ready_o;
        pop      = !alu_live && count_o != '0;
        bypass   = acc && mem_rd_i != 5'd0 && !alu_live && count_o == '0;
        push     = acc && mem_rd_i != 5'd0 && !bypass;
    end
    always_comb begin
        pending_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (q_vld[i] && !q_kill[i]) pending_o[q_rd[i]] = 1'b1;
        pending_o[0] = 1'b0;
    end
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_rd[wp]   <= mem_rd_i;
            q_data[wp] <= mem_data_i;
        end
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q_vld      <= '0;
            q_kill     <= '0;
            wp         <= '0;
            rp         <= '0;
            count_o    <= '0;
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
        end else begin
            // stale slots may get flagged too; a push rewrites its flag
            for (int i = 0; i < DEPTH; i++)
                if (alu_live && q_rd[i] == alu_rd_i) q_kill[i] <= 1'b1;
            if (pop) begin
                q_vld[rp] <= 1'b0;
                rp        <= rp + 1'b1;
            end
            // a load pushed alongside an ALU write to the same rd is the older write
            if (push) begin
                q_vld[wp]  <= 1'b1;
                q_kill[wp] <= alu_live && alu_rd_i == mem_rd_i;
                wp         <= wp + 1'b1;
            end
            count_o    <= count_o + CW'(push) - CW'(pop);
            RegWrite_o <= alu_live || bypass || (pop && !q_kill[rp]);
            RDaddr_o   <= alu_live ? alu_rd_i : pop ? q_rd[rp] : bypass ? mem_rd_i : RDaddr_o;
            RDdata_o   <= alu_live ? alu_data_i : pop ? q_data[rp] : bypass ? mem_data_i : RDdata_o;
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed self-checking bench for wb_write_arbiter
module tb_wb_write_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0;
    logic [31:0] alu_data_i = '0;
    logic        mem_valid_i = 1'b0;
    logic [4:0]  mem_rd_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        mem_ready_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic        RegWrite_o;
    logic [31:0] pending_o;
    logic [2:0]  count_o;
    int errors = 0;
    int checks = 0;

    wb_write_arbiter #(.DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
        .mem_ready_o(mem_ready_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
        .RegWrite_o(RegWrite_o), .pending_o(pending_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        alu_valid_i = av;
        alu_rd_i    = ard;
        alu_data_i  = ad;
        mem_valid_i = mv;
        mem_rd_i    = mrd;
        mem_data_i  = md;
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, pending_o, count_o, mem_ready_o} !== {1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset: we=%b addr=%0d data=%h pend=%h cnt=%0d rdy=%b, want 0 0 0 0 0 1",
                     RegWrite_o, RDaddr_o, RDdata_o, pending_o, count_o, mem_ready_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        tick;
        checks++;
        if (RegWrite_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: we=%b want 0", RegWrite_o);
        end
    endtask

    task automatic test_bypass;
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        checks++;
        if (mem_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bypass_ready: got %b want 1", mem_ready_o);
        end
        tick;
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, count_o} !== {1'b1, 5'd5, 32'hDEADBEEF, 3'd0}) begin
            errors++;
            $display("FAIL bypass_write: we=%b addr=%0d data=%h cnt=%0d want 1 5 deadbeef 0",
                     RegWrite_o, RDaddr_o, RDdata_o, count_o);
        end
        tick;
        checks++;
        if (RegWrite_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_idle: we=%b want 0", RegWrite_o);
        end
    endtask

    task automatic test_alu_and_load;
        drive(1, 5'd3, 32'h22, 1, 5'd7, 32'h11);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, pending_o, count_o} !== {1'b1, 5'd3, 32'h22, 32'h80, 3'd1}) begin
            errors++;
            $display("FAIL alu_first: we=%b addr=%0d data=%h pend=%h cnt=%0d want 1 3 22 80 1",
                     RegWrite_o, RDaddr_o, RDdata_o, pending_o, count_o);
        end
        tick;
        checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, pending_o, count_o} !== {1'b1, 5'd7, 32'h11, 32'h0, 3'd0}) begin
            errors++;
            $display("FAIL load_second: we=%b addr=%0d data=%h pend=%h cnt=%0d want 1 7 11 0 0",
                     RegWrite_o, RDaddr_o, RDdata_o, pending_o, count_o);
        end
    endtask

    task automatic test_waw;
        drive(1, 5'd1, 32'h1, 1, 5'd9, 32'hAA);
        tick;
        checks++;
        if ({pending_o, count_o} !== {32'h200, 3'd1}) begin
            errors++;
            $display("FAIL waw_queued: pend=%h cnt=%0d want 200 1", pending_o, count_o);
        end
        drive(1, 5'd9, 32'hBB, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, pending_o, count_o} !== {1'b1, 5'd9, 32'hBB, 32'h0, 3'd1}) begin
            errors++;
            $display("FAIL waw_kill: we=%b addr=%0d data=%h pend=%h cnt=%0d want 1 9 bb 0 1",
                     RegWrite_o, RDaddr_o, RDdata_o, pending_o, count_o);
        end
        tick;
        checks++;
        if ({RegWrite_o, count_o} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL waw_pop_killed: we=%b cnt=%0d want 0 0", RegWrite_o, count_o);
        end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(20 + i), 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i));
            checks++;
            if (mem_ready_o !== (i < 4)) begin
                errors++;
                $display("FAIL fill_ready[%0d]: got %b want %b", i, mem_ready_o, i < 4);
            end
            tick;
            checks++;
            if ({RegWrite_o, RDaddr_o} !== {1'b1, 5'(20 + i)}) begin
                errors++;
                $display("FAIL fill_alu[%0d]: we=%b addr=%0d want 1 %0d", i, RegWrite_o, RDaddr_o, 20 + i);
            end
        end
        checks++;
        if ({count_o, mem_ready_o} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL fill_full: cnt=%0d rdy=%b want 4 0", count_o, mem_ready_o);
        end
        drive(0, 0, 0, 1, 5'd14, 32'h104);
        tick;
        checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, count_o, mem_ready_o} !== {1'b1, 5'd10, 32'h100, 3'd3, 1'b1}) begin
            errors++;
            $display("FAIL fill_drain0: we=%b addr=%0d data=%h cnt=%0d rdy=%b want 1 10 100 3 1",
                     RegWrite_o, RDaddr_o, RDdata_o, count_o, mem_ready_o);
        end
        tick;
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, count_o} !== {1'b1, 5'd11, 32'h101, 3'd3}) begin
            errors++;
            $display("FAIL fill_drain1: we=%b addr=%0d data=%h cnt=%0d want 1 11 101 3",
                     RegWrite_o, RDaddr_o, RDdata_o, count_o);
        end
        for (int j = 2; j < 5; j++) begin
            tick;
            checks++;
            if ({RegWrite_o, RDaddr_o, RDdata_o, count_o} !== {1'b1, 5'(10 + j), 32'h100 + 32'(j), 3'(4 - j)}) begin
                errors++;
                $display("FAIL fill_drain%0d: we=%b addr=%0d data=%h cnt=%0d want 1 %0d %h %0d",
                         j, RegWrite_o, RDaddr_o, RDdata_o, count_o, 10 + j, 32'h100 + 32'(j), 4 - j);
            end
        end
    endtask

    task automatic test_x0;
        drive(1, 5'd2, 32'h2, 1, 5'd6, 32'h66);
        tick;
        drive(1, 5'd0, 32'h99, 0, 0, 0);
        tick;
        checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, count_o} !== {1'b1, 5'd6, 32'h66, 3'd0}) begin
            errors++;
            $display("FAIL x0_alu: we=%b addr=%0d data=%h cnt=%0d want 1 6 66 0",
                     RegWrite_o, RDaddr_o, RDdata_o, count_o);
        end
        drive(0, 0, 0, 1, 5'd0, 32'h77);
        checks++;
        if (mem_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %b want 1", mem_ready_o);
        end
        tick;
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if ({RegWrite_o, count_o, pending_o} !== {1'b0, 3'd0, 32'h0}) begin
            errors++;
            $display("FAIL x0_load: we=%b cnt=%0d pend=%h want 0 0 0", RegWrite_o, count_o, pending_o);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(1 + i), 32'(i), 1, 5'(11 + i), 32'h300 + 32'(i));
            tick;
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if ({count_o, pending_o} !== {3'd3, 32'h3800}) begin
            errors++;
            $display("FAIL mid_fill: cnt=%0d pend=%h want 3 3800", count_o, pending_o);
        end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({RegWrite_o, count_o, pending_o, mem_ready_o} !== {1'b0, 3'd0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: we=%b cnt=%0d pend=%h rdy=%b want 0 0 0 1",
                     RegWrite_o, count_o, pending_o, mem_ready_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if ({RegWrite_o, count_o} !== {1'b0, 3'd0}) begin
                errors++;
                $display("FAIL mid_stale[%0d]: we=%b cnt=%0d want 0 0", i, RegWrite_o, count_o);
            end
        end
    endtask

    initial begin
        #2;
        test_reset;
        test_bypass;
        test_alu_and_load;
        test_waw;
        test_fill;
        test_x0;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
